// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-address sequencer: vector spacing,
// redirect-source encoding and the return-stack depth width helper.
package pc_sequencer_pkg;

  // Interrupt vectors are spaced 4 words apart.
  localparam int VEC_SHIFT = 2;

  typedef enum logic [2:0] {
    NONE,
    IRQ,
    CALL,
    RET,
    JMP,
    MISS,
    STALL,
    INC
  } redirect_e;

  function automatic int depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Circular return-address stack with sticky overflow/underflow flags.
// Push and pop take effect in the accepting cycle; the top is read combinationally.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             err_clr,
  input  logic [ADDR_W-1:0]                data_in,
  output logic [ADDR_W-1:0]                data_out,
  output logic [depth_w(STACK_DEPTH)-1:0]  depth,
  output logic                             ovf,
  output logic                             unf
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int DW    = depth_w(STACK_DEPTH);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic              full;
  logic              empty;

  assign full  = (depth == FULL);
  assign empty = (depth == '0);

  // An empty pop re-reads the slot that was popped last, which sp still points at.
  assign data_out = empty ? mem[sp] : mem[sp - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push) begin
        sp <= sp + PTR_W'(1);
        if (!full) depth <= depth + DW'(1);
      end else if (pop && !empty) begin
        sp    <= sp - PTR_W'(1);
        depth <= depth - DW'(1);
      end
      ovf <= (ovf & ~err_clr) | (push & full);
      unf <= (unf & ~err_clr) | (pop & empty);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: prioritised redirects (irq/call/ret/jmp), cache-miss
// replay, stall hold and sequential increment, with a tracked pipeline address chain.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INT_W       = 3,
  parameter int PIPE_DEPTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic                             miss,
  input  logic                             jmp,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             irq,
  input  logic [ADDR_W-1:0]                jmp_target,
  input  logic [ADDR_W-1:0]                call_target,
  input  logic [INT_W-1:0]                 irq_vec,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                addr,
  output logic                             flush,
  output logic [depth_w(STACK_DEPTH)-1:0]  stk_depth,
  output logic                             stk_ovf,
  output logic                             stk_unf
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] stage [PIPE_DEPTH];
  logic              miss_hold;
  redirect_e         sel;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] stk_top;

  assign addr = pc;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .err_clr  (err_clr),
    .data_in  (push_data),
    .data_out (stk_top),
    .depth    (stk_depth),
    .ovf      (stk_ovf),
    .unf      (stk_unf)
  );

  // Strict priority: only the winning request has any effect this cycle.
  always_comb begin
    sel       = NONE;
    pc_next   = pc;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = stage[PIPE_DEPTH-1];
    if (irq) begin
      sel     = IRQ;
      pc_next = ADDR_W'(irq_vec) << VEC_SHIFT;
      push    = 1'b1;
    end else if (call) begin
      sel       = CALL;
      pc_next   = call_target;
      push      = 1'b1;
      push_data = stage[PIPE_DEPTH-1] + ADDR_W'(1);
    end else if (ret) begin
      sel     = RET;
      pc_next = stk_top;
      pop     = 1'b1;
    end else if (jmp) begin
      sel     = JMP;
      pc_next = jmp_target;
    end else if (miss) begin
      sel = MISS;
      if (!miss_hold) pc_next = prev_addr;
    end else if (stall) begin
      sel = STALL;
    end else begin
      sel     = INC;
      pc_next = pc + ADDR_W'(1);
    end
  end

  assign redirect = (sel == IRQ) || (sel == CALL) || (sel == RET) || (sel == JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      prev_addr <= '0;
      miss_hold <= 1'b0;
      flush     <= 1'b0;
      for (int k = 0; k < PIPE_DEPTH; k++) stage[k] <= '0;
    end else begin
      pc        <= pc_next;
      prev_addr <= pc;
      miss_hold <= miss;
      flush     <= redirect;
      if (redirect) begin
        for (int k = 0; k < PIPE_DEPTH; k++) stage[k] <= pc_next;
      end else if (!stall && !miss) begin
        stage[0] <= pc;
        for (int k = 1; k < PIPE_DEPTH; k++) stage[k] <= stage[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: a default 16-bit instance
// for sequencing/stack behaviour and an 8-bit instance for wrap and reset checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, miss, jmp, call, ret, irq, err_clr;
  logic [15:0] jmp_target, call_target;
  logic [2:0]  irq_vec;
  logic [15:0] addr;
  logic        flush, stk_ovf, stk_unf;
  logic [3:0]  stk_depth;

  logic        rst8_n, miss8, jmp8, zero8;
  logic [7:0]  tgt8, zaddr8;
  logic [2:0]  zvec8;
  logic [7:0]  addr8;
  logic        flush8, ovf8, unf8;
  logic [3:0]  depth8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .miss(miss), .jmp(jmp), .call(call),
    .ret(ret), .irq(irq), .jmp_target(jmp_target), .call_target(call_target),
    .irq_vec(irq_vec), .err_clr(err_clr), .addr(addr), .flush(flush),
    .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  pc_sequencer #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .stall(zero8), .miss(miss8), .jmp(jmp8), .call(zero8),
    .ret(zero8), .irq(zero8), .jmp_target(tgt8), .call_target(zaddr8),
    .irq_vec(zvec8), .err_clr(zero8), .addr(addr8), .flush(flush8),
    .stk_depth(depth8), .stk_ovf(ovf8), .stk_unf(unf8)
  );

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; miss = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    irq = 1'b0; err_clr = 1'b0; jmp_target = '0; call_target = '0; irq_vec = '0;
    rst8_n = 1'b0; miss8 = 1'b0; jmp8 = 1'b0; zero8 = 1'b0; tgt8 = '0; zaddr8 = '0; zvec8 = '0;

    applyStimulus(2);
    checkOutput("reset_addr", 32'(addr), 32'h0);
    checkOutput("reset_flush", 32'(flush), 32'h0);
    checkOutput("reset_depth", 32'(stk_depth), 32'h0);
    checkOutput("reset_ovf", 32'(stk_ovf), 32'h0);
    checkOutput("reset_unf", 32'(stk_unf), 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("inc_addr_%0d", i), 32'(addr), 32'(i));
      checkOutput($sformatf("inc_flush_%0d", i), 32'(flush), 32'h0);
    end

    applyStimulus(11);
    checkOutput("pre_call_addr", 32'(addr), 32'h10);

    // Call at 0x10: stage2 holds 0x0D, so 0x0E is pushed.
    call = 1'b1; call_target = 16'h0200;
    applyStimulus(1);
    call = 1'b0;
    checkOutput("call_addr", 32'(addr), 32'h200);
    checkOutput("call_flush", 32'(flush), 32'h1);
    checkOutput("call_depth", 32'(stk_depth), 32'h1);
    applyStimulus(1);
    checkOutput("post_call_flush", 32'(flush), 32'h0);
    checkOutput("post_call_addr", 32'(addr), 32'h201);

    stall = 1'b1;
    applyStimulus(2);
    stall = 1'b0;
    checkOutput("stall_hold", 32'(addr), 32'h201);
    applyStimulus(2);
    checkOutput("pre_ret_addr", 32'(addr), 32'h203);

    ret = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    checkOutput("ret_addr", 32'(addr), 32'h0E);
    checkOutput("ret_flush", 32'(flush), 32'h1);
    checkOutput("ret_depth", 32'(stk_depth), 32'h0);
    applyStimulus(1);
    checkOutput("post_ret_addr", 32'(addr), 32'h0F);
    checkOutput("post_ret_flush", 32'(flush), 32'h0);

    // irq beats call and jmp, even while stalled; pushes stage2 (0x0E).
    irq = 1'b1; call = 1'b1; jmp = 1'b1; stall = 1'b1; irq_vec = 3'd5;
    call_target = 16'h0AAA; jmp_target = 16'h0BBB;
    applyStimulus(1);
    irq = 1'b0; call = 1'b0; jmp = 1'b0; stall = 1'b0;
    checkOutput("irq_addr", 32'(addr), 32'h14);
    checkOutput("irq_flush", 32'(flush), 32'h1);
    checkOutput("irq_depth", 32'(stk_depth), 32'h1);
    ret = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    checkOutput("irq_ret_addr", 32'(addr), 32'h0E);

    // Nine back-to-back calls; call k targets 0x1000 + 0x10*k.
    for (int k = 1; k <= 9; k++) begin
      call = 1'b1; call_target = 16'(16'h1000 + 16'h10 * k);
      applyStimulus(1);
      checkOutput($sformatf("ovf_call_addr_%0d", k), 32'(addr), 32'(16'h1000 + 16'h10 * k));
      checkOutput($sformatf("ovf_call_depth_%0d", k), 32'(stk_depth), 32'((k > 8) ? 8 : k));
      checkOutput($sformatf("ovf_flag_%0d", k), 32'(stk_ovf), 32'((k == 9) ? 1 : 0));
    end
    call = 1'b0;

    // Rets return targets 8..1 (+1) newest-first; the ninth replays the last slot.
    for (int j = 1; j <= 9; j++) begin
      ret = 1'b1;
      applyStimulus(1);
      checkOutput($sformatf("unf_ret_addr_%0d", j), 32'(addr),
                  32'(16'h1001 + 16'h10 * ((j == 9) ? 1 : (9 - j))));
      checkOutput($sformatf("unf_ret_depth_%0d", j), 32'(stk_depth), 32'((j >= 8) ? 0 : (8 - j)));
      checkOutput($sformatf("unf_flag_%0d", j), 32'(stk_unf), 32'((j == 9) ? 1 : 0));
    end

    // Underflow set with err_clr in the same cycle keeps unf; ovf clears.
    err_clr = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    checkOutput("clr_same_unf", 32'(stk_unf), 32'h1);
    checkOutput("clr_same_ovf", 32'(stk_ovf), 32'h0);
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("clr_unf", 32'(stk_unf), 32'h0);

    jmp = 1'b1; jmp_target = 16'h0040;
    applyStimulus(1);
    jmp = 1'b0;
    checkOutput("jmp_addr", 32'(addr), 32'h40);
    checkOutput("jmp_depth", 32'(stk_depth), 32'h0);
    applyStimulus(1);
    checkOutput("pre_miss_addr", 32'(addr), 32'h41);

    miss = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      applyStimulus(1);
      checkOutput($sformatf("miss_hold_%0d", m), 32'(addr), 32'h40);
    end
    checkOutput("miss_no_flush", 32'(flush), 32'h0);
    miss = 1'b0;
    applyStimulus(1);
    checkOutput("miss_resume", 32'(addr), 32'h41);

    // 8-bit instance: wrap, then reset asserted mid-redirect/mid-miss.
    rst8_n = 1'b1;
    jmp8 = 1'b1; tgt8 = 8'hFF;
    applyStimulus(1);
    jmp8 = 1'b0;
    checkOutput("w8_jmp_addr", 32'(addr8), 32'hFF);
    applyStimulus(1);
    checkOutput("w8_wrap_addr", 32'(addr8), 32'h00);
    checkOutput("w8_wrap_ovf", 32'(ovf8), 32'h0);
    checkOutput("w8_wrap_unf", 32'(unf8), 32'h0);
    miss8 = 1'b1;
    applyStimulus(1);
    checkOutput("w8_miss_addr", 32'(addr8), 32'hFF);
    miss8 = 1'b0; jmp8 = 1'b1; tgt8 = 8'h55;
    applyStimulus(1);
    jmp8 = 1'b0; miss8 = 1'b1;
    checkOutput("w8_redirect_flush", 32'(flush8), 32'h1);
    #2 rst8_n = 1'b0;
    #1;
    checkOutput("w8_rst_addr", 32'(addr8), 32'h0);
    checkOutput("w8_rst_flush", 32'(flush8), 32'h0);
    checkOutput("w8_rst_depth", 32'(depth8), 32'h0);
    miss8 = 1'b0;
    #1 rst8_n = 1'b1;
    applyStimulus(1);
    checkOutput("w8_release_addr", 32'(addr8), 32'h1);
    checkOutput("w8_release_flush", 32'(flush8), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
